// File: rtl/alu_operand_stage_if.sv
// Decode-to-execute operand stage bus.
// Carries the decode-side instruction fields, the forwarding network taps
// and the registered execute-side operands with their valid/ready handshake.
// The slave modport is the operand stage; master is whoever drives decode
// and consumes the execute operands (pipeline glue or a testbench).
interface alu_operand_stage_if #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2
);
    // Stage control
    logic                      flush_i;
    logic                      valid_i;
    logic                      ready_o;

    // Decoded instruction fields
    logic [6:0]                opcode_i;
    logic [4:0]                rs1_addr_i;
    logic [4:0]                rs2_addr_i;
    logic [XLEN-1:0]           rs1_data_i;
    logic [XLEN-1:0]           rs2_data_i;
    logic [XLEN-1:0]           pc_i;
    logic [XLEN-1:0]           i_imm_i;
    logic [XLEN-1:0]           s_imm_i;
    logic [XLEN-1:0]           b_imm_i;
    logic [XLEN-1:0]           u_imm_i;
    logic [XLEN-1:0]           j_imm_i;

    // Forwarding network, entry 0 is the youngest
    logic [NUM_FWD-1:0]        fwd_valid_i;
    logic [NUM_FWD-1:0]        fwd_pending_i;
    logic [5*NUM_FWD-1:0]      fwd_addr_i;
    logic [XLEN*NUM_FWD-1:0]   fwd_data_i;

    // Execute-side registered outputs
    logic                      valid_o;
    logic                      ready_i;
    logic [XLEN-1:0]           alu_a_o;
    logic [XLEN-1:0]           alu_b_o;
    logic [XLEN-1:0]           rs1_o;
    logic [XLEN-1:0]           rs2_o;
    logic [1:0]                alu_a_src_o;
    logic [1:0]                alu_b_src_o;

    modport slave (
        input  flush_i, valid_i,
        input  opcode_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i,
        input  pc_i, i_imm_i, s_imm_i, b_imm_i, u_imm_i, j_imm_i,
        input  fwd_valid_i, fwd_pending_i, fwd_addr_i, fwd_data_i,
        input  ready_i,
        output ready_o, valid_o,
        output alu_a_o, alu_b_o, rs1_o, rs2_o, alu_a_src_o, alu_b_src_o
    );

    modport master (
        output flush_i, valid_i,
        output opcode_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i,
        output pc_i, i_imm_i, s_imm_i, b_imm_i, u_imm_i, j_imm_i,
        output fwd_valid_i, fwd_pending_i, fwd_addr_i, fwd_data_i,
        output ready_i,
        input  ready_o, valid_o,
        input  alu_a_o, alu_b_o, rs1_o, rs2_o, alu_a_src_o, alu_b_src_o
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage.
// Decodes the opcode into A/B operand selects, resolves rs1/rs2 through a
// prioritised forwarding network (entry 0 youngest), muxes the operands and
// registers them into the decode-to-execute pipeline register behind a
// valid/ready handshake. A load-use hazard on a used source stalls the
// handshake; flush kills the held instruction and refuses the input.
module alu_operand_stage #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    alu_operand_stage_if.slave bus
);
    // RV64 major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_W     = 7'b0111011;

    // A operand selects
    localparam logic [1:0] A_SEL_RS1  = 2'd0;
    localparam logic [1:0] A_SEL_UIMM = 2'd1;
    localparam logic [1:0] A_SEL_JIMM = 2'd2;
    localparam logic [1:0] A_SEL_BIMM = 2'd3;

    // B operand selects
    localparam logic [1:0] B_SEL_RS2  = 2'd0;
    localparam logic [1:0] B_SEL_PC   = 2'd1;
    localparam logic [1:0] B_SEL_SIMM = 2'd2;
    localparam logic [1:0] B_SEL_IIMM = 2'd3;

    // Decode results
    logic [1:0]         a_sel;
    logic [1:0]         b_sel;
    logic               rs1_used;
    logic               rs2_used;

    // Forwarding match vectors, one bit per entry
    logic [NUM_FWD-1:0] rs1_match;
    logic [NUM_FWD-1:0] rs2_match;

    // Winning forward per source
    logic               rs1_hit;
    logic               rs1_pend;
    logic [XLEN-1:0]    rs1_fwd_data;
    logic               rs2_hit;
    logic               rs2_pend;
    logic [XLEN-1:0]    rs2_fwd_data;

    // Resolved register values and muxed operands
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;
    logic [XLEN-1:0]    alu_a;
    logic [XLEN-1:0]    alu_b;

    // Handshake
    logic               hazard;
    logic               ready;
    logic               load;

    // Pipeline register
    logic               valid_q,     valid_d;
    logic [XLEN-1:0]    alu_a_q;
    logic [XLEN-1:0]    alu_b_q;
    logic [XLEN-1:0]    rs1_q;
    logic [XLEN-1:0]    rs2_q;
    logic [1:0]         a_src_q;
    logic [1:0]         b_src_q;

    // Opcode decode: operand selects and which source registers are read
    always_comb begin
        a_sel    = A_SEL_RS1;
        b_sel    = B_SEL_RS2;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (bus.opcode_i)
            OPC_LUI: begin
                a_sel    = A_SEL_UIMM;
                rs1_used = 1'b0;
            end
            OPC_AUIPC: begin
                a_sel    = A_SEL_UIMM;
                b_sel    = B_SEL_PC;
                rs1_used = 1'b0;
            end
            OPC_JAL: begin
                a_sel    = A_SEL_JIMM;
                b_sel    = B_SEL_PC;
                rs1_used = 1'b0;
            end
            OPC_JALR: begin
                b_sel    = B_SEL_IIMM;
            end
            OPC_BRANCH: begin
                a_sel    = A_SEL_BIMM;
                b_sel    = B_SEL_PC;
                rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                b_sel    = B_SEL_IIMM;
            end
            OPC_STORE: begin
                b_sel    = B_SEL_SIMM;
                rs2_used = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_W: begin
                b_sel    = B_SEL_IIMM;
            end
            OPC_OP, OPC_OP_W: begin
                rs2_used = 1'b1;
            end
            default: begin
                // Unknown opcodes behave like a register-register op on rs1
                // only, so they still respect rs1 load-use hazards.
            end
        endcase
    end

    // Per-entry match; x0 never matches so it always reads the register file
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_match
            assign rs1_match[gi] = bus.fwd_valid_i[gi]
                                 && (bus.fwd_addr_i[5*gi +: 5] == bus.rs1_addr_i)
                                 && (bus.rs1_addr_i != 5'd0);
            assign rs2_match[gi] = bus.fwd_valid_i[gi]
                                 && (bus.fwd_addr_i[5*gi +: 5] == bus.rs2_addr_i)
                                 && (bus.rs2_addr_i != 5'd0);
        end
    endgenerate

    // Priority pick: walk from oldest to youngest so the lowest index wins
    always_comb begin
        rs1_hit      = 1'b0;
        rs1_pend     = 1'b0;
        rs1_fwd_data = '0;
        rs2_hit      = 1'b0;
        rs2_pend     = 1'b0;
        rs2_fwd_data = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (rs1_match[k]) begin
                rs1_hit      = 1'b1;
                rs1_pend     = bus.fwd_pending_i[k];
                rs1_fwd_data = bus.fwd_data_i[XLEN*k +: XLEN];
            end
            if (rs2_match[k]) begin
                rs2_hit      = 1'b1;
                rs2_pend     = bus.fwd_pending_i[k];
                rs2_fwd_data = bus.fwd_data_i[XLEN*k +: XLEN];
            end
        end
    end

    // Forwarded data only replaces the register file once it has arrived;
    // a pending winner leaves the register-file value (and stalls if used).
    assign rs1_val = (rs1_hit && !rs1_pend) ? rs1_fwd_data : bus.rs1_data_i;
    assign rs2_val = (rs2_hit && !rs2_pend) ? rs2_fwd_data : bus.rs2_data_i;

    // Final operand muxes
    always_comb begin
        alu_a = rs1_val;
        case (a_sel)
            A_SEL_UIMM: alu_a = bus.u_imm_i;
            A_SEL_JIMM: alu_a = bus.j_imm_i;
            A_SEL_BIMM: alu_a = bus.b_imm_i;
            default:    alu_a = rs1_val;
        endcase
        alu_b = rs2_val;
        case (b_sel)
            B_SEL_PC:   alu_b = bus.pc_i;
            B_SEL_SIMM: alu_b = bus.s_imm_i;
            B_SEL_IIMM: alu_b = bus.i_imm_i;
            default:    alu_b = rs2_val;
        endcase
    end

    // Load-use hazard only for sources the opcode actually reads
    assign hazard = bus.valid_i && !bus.flush_i
                  && ((rs1_used && rs1_hit && rs1_pend)
                   || (rs2_used && rs2_hit && rs2_pend));

    assign ready = (!valid_q || bus.ready_i) && !hazard && !bus.flush_i;
    assign load  = bus.valid_i && ready;

    // Valid next state: flush wins, then load, then drain on consume
    always_comb begin
        valid_d = valid_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Valid flag register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Operand/select registers capture on load and hold otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            a_src_q <= A_SEL_RS1;
            b_src_q <= B_SEL_RS2;
        end else if (load) begin
            alu_a_q <= alu_a;
            alu_b_q <= alu_b;
            rs1_q   <= rs1_val;
            rs2_q   <= rs2_val;
            a_src_q <= a_sel;
            b_src_q <= b_sel;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = valid_q;
    assign bus.alu_a_o     = alu_a_q;
    assign bus.alu_b_o     = alu_b_q;
    assign bus.rs1_o       = rs1_q;
    assign bus.rs2_o       = rs2_q;
    assign bus.alu_a_src_o = a_src_q;
    assign bus.alu_b_src_o = b_src_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed vectors with hand-computed
// expectations pushed into a scoreboard; a negedge monitor pops and compares
// on every execute-side transfer.
module tb_alu_operand_stage;
    localparam int XLEN    = 64;
    localparam int NUM_FWD = 2;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_W     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r1;
        logic [63:0] r2;
        logic [1:0]  as;
        logic [1:0]  bs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [63:0] d1, input logic [63:0] d2);
        bus.valid_i    = 1'b1;
        bus.opcode_i   = opc;
        bus.rs1_addr_i = a1;
        bus.rs2_addr_i = a2;
        bus.rs1_data_i = d1;
        bus.rs2_data_i = d2;
    endtask

    task automatic set_fwd(input int k, input logic v, input logic p,
                           input logic [4:0] addr, input logic [63:0] data);
        bus.fwd_valid_i[k]              = v;
        bus.fwd_pending_i[k]            = p;
        bus.fwd_addr_i[5*k +: 5]        = addr;
        bus.fwd_data_i[XLEN*k +: XLEN]  = data;
    endtask

    task automatic clear_fwd();
        for (int k = 0; k < NUM_FWD; k++) set_fwd(k, 1'b0, 1'b0, 5'd0, 64'd0);
    endtask

    // Wait (bounded) for ready_o, record the expectation, then let the edge load it
    task automatic accept(input string name, input logic [63:0] ea, input logic [63:0] eb,
                          input logic [63:0] er1, input logic [63:0] er2,
                          input logic [1:0] eas, input logic [1:0] ebs, input int max_wait);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!bus.ready_o && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        n_checks++;
        if (!bus.ready_o || waited > max_wait) begin
            n_fail++;
            $display("FAIL %s accept: ready_o=%0b after %0d stall cycles, allowed %0d",
                     name, bus.ready_o, waited, max_wait);
        end
        if (bus.ready_o) begin
            e.name = name; e.a = ea; e.b = eb; e.r1 = er1; e.r2 = er2; e.as = eas; e.bs = ebs;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every execute-side transfer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.valid_o && bus.ready_i) begin
            n_checks++;
            n_txn++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL txn %0d unexpected output: a=%0h b=%0h rs1=%0h rs2=%0h",
                         n_txn, bus.alu_a_o, bus.alu_b_o, bus.rs1_o, bus.rs2_o);
            end else begin
                mon_e = sb.pop_front();
                if (bus.alu_a_o !== mon_e.a || bus.alu_b_o !== mon_e.b ||
                    bus.rs1_o !== mon_e.r1 || bus.rs2_o !== mon_e.r2 ||
                    bus.alu_a_src_o !== mon_e.as || bus.alu_b_src_o !== mon_e.bs) begin
                    n_fail++;
                    $display("FAIL txn %0d %s: got a=%0h b=%0h rs1=%0h rs2=%0h sel=%0d/%0d, expected a=%0h b=%0h rs1=%0h rs2=%0h sel=%0d/%0d",
                             n_txn, mon_e.name, bus.alu_a_o, bus.alu_b_o, bus.rs1_o, bus.rs2_o,
                             bus.alu_a_src_o, bus.alu_b_src_o, mon_e.a, mon_e.b, mon_e.r1,
                             mon_e.r2, mon_e.as, mon_e.bs);
                end else begin
                    $display("txn %0d %s ok: a=%0h b=%0h rs1=%0h rs2=%0h sel=%0d/%0d",
                             n_txn, mon_e.name, bus.alu_a_o, bus.alu_b_o, bus.rs1_o,
                             bus.rs2_o, bus.alu_a_src_o, bus.alu_b_src_o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Select sweep table
    logic [6:0]  sw_op [12];
    logic [63:0] sw_a  [12];
    logic [63:0] sw_b  [12];
    logic [1:0]  sw_as [12];
    logic [1:0]  sw_bs [12];

    initial begin
        exp_t dropped;

        sw_op[0]  = OPC_LUI;      sw_a[0]  = 64'h444; sw_b[0]  = 64'hB2;   sw_as[0]  = 2'd1; sw_bs[0]  = 2'd0;
        sw_op[1]  = OPC_AUIPC;    sw_a[1]  = 64'h444; sw_b[1]  = 64'h1000; sw_as[1]  = 2'd1; sw_bs[1]  = 2'd1;
        sw_op[2]  = OPC_JAL;      sw_a[2]  = 64'h555; sw_b[2]  = 64'h1000; sw_as[2]  = 2'd2; sw_bs[2]  = 2'd1;
        sw_op[3]  = OPC_JALR;     sw_a[3]  = 64'hA1;  sw_b[3]  = 64'h111;  sw_as[3]  = 2'd0; sw_bs[3]  = 2'd3;
        sw_op[4]  = OPC_BRANCH;   sw_a[4]  = 64'h333; sw_b[4]  = 64'h1000; sw_as[4]  = 2'd3; sw_bs[4]  = 2'd1;
        sw_op[5]  = OPC_LOAD;     sw_a[5]  = 64'hA1;  sw_b[5]  = 64'h111;  sw_as[5]  = 2'd0; sw_bs[5]  = 2'd3;
        sw_op[6]  = OPC_STORE;    sw_a[6]  = 64'hA1;  sw_b[6]  = 64'h222;  sw_as[6]  = 2'd0; sw_bs[6]  = 2'd2;
        sw_op[7]  = OPC_OP_IMM;   sw_a[7]  = 64'hA1;  sw_b[7]  = 64'h111;  sw_as[7]  = 2'd0; sw_bs[7]  = 2'd3;
        sw_op[8]  = OPC_OP_IMM_W; sw_a[8]  = 64'hA1;  sw_b[8]  = 64'h111;  sw_as[8]  = 2'd0; sw_bs[8]  = 2'd3;
        sw_op[9]  = OPC_OP;       sw_a[9]  = 64'hA1;  sw_b[9]  = 64'hB2;   sw_as[9]  = 2'd0; sw_bs[9]  = 2'd0;
        sw_op[10] = OPC_OP_W;     sw_a[10] = 64'hA1;  sw_b[10] = 64'hB2;   sw_as[10] = 2'd0; sw_bs[10] = 2'd0;
        sw_op[11] = OPC_SYSTEM;   sw_a[11] = 64'hA1;  sw_b[11] = 64'hB2;   sw_as[11] = 2'd0; sw_bs[11] = 2'd0;

        // Reset held with an AUIPC presented
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.pc_i    = 64'h1000;
        bus.i_imm_i = 64'h111;
        bus.s_imm_i = 64'h222;
        bus.b_imm_i = 64'h333;
        bus.u_imm_i = 64'h5000;
        bus.j_imm_i = 64'h555;
        clear_fwd();
        set_instr(OPC_AUIPC, 5'd1, 5'd2, 64'h10, 64'h20);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {63'd0, bus.valid_o}, 64'd0);
        check("reset_alu_a", bus.alu_a_o, 64'd0);
        check("reset_alu_b", bus.alu_b_o, 64'd0);
        check("reset_rs1",   bus.rs1_o, 64'd0);
        check("reset_rs2",   bus.rs2_o, 64'd0);
        check("reset_srcs",  {60'd0, bus.alu_a_src_o, bus.alu_b_src_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        accept("auipc_after_reset", 64'h5000, 64'h1000, 64'h10, 64'h20, 2'd1, 2'd1, 0);
        bus.u_imm_i = 64'h444;

        // Forwarding priority
        set_instr(OPC_OP, 5'd5, 5'd6, 64'h1, 64'h2);
        set_fwd(0, 1'b1, 1'b0, 5'd5, 64'hAA);
        set_fwd(1, 1'b1, 1'b0, 5'd5, 64'hBB);
        accept("fwd_youngest_wins", 64'hAA, 64'h2, 64'hAA, 64'h2, 2'd0, 2'd0, 0);
        set_fwd(0, 1'b1, 1'b0, 5'd7, 64'h99);
        set_fwd(1, 1'b1, 1'b0, 5'd6, 64'hCC);
        accept("fwd_entry1_rs2", 64'h1, 64'hCC, 64'h1, 64'hCC, 2'd0, 2'd0, 0);
        set_fwd(0, 1'b1, 1'b0, 5'd6, 64'hCC);
        set_fwd(1, 1'b1, 1'b1, 5'd6, 64'hEE);
        accept("fwd_pending_shadowed", 64'h1, 64'hCC, 64'h1, 64'hCC, 2'd0, 2'd0, 0);

        // x0 is never forwarded, even with pending entries targeting it
        set_instr(OPC_OP, 5'd0, 5'd0, 64'h31, 64'h32);
        set_fwd(0, 1'b1, 1'b1, 5'd0, 64'hF0);
        set_fwd(1, 1'b1, 1'b0, 5'd0, 64'hF1);
        accept("x0_reads_rf", 64'h31, 64'h32, 64'h31, 64'h32, 2'd0, 2'd0, 0);

        // Load-use on STORE rs2
        set_instr(OPC_STORE, 5'd3, 5'd7, 64'h33, 64'h44);
        set_fwd(0, 1'b1, 1'b1, 5'd7, 64'hDEAD);
        set_fwd(1, 1'b0, 1'b0, 5'd0, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("loaduse_rs2_stall", {63'd0, bus.ready_o}, 64'd0);
        end
        @(posedge clk);
        #1;
        set_fwd(0, 1'b1, 1'b0, 5'd7, 64'h77);
        accept("loaduse_rs2_release", 64'h33, 64'h222, 64'h33, 64'h77, 2'd0, 2'd2, 0);

        // Unlisted opcode uses rs1 for hazards
        set_instr(OPC_SYSTEM, 5'd9, 5'd0, 64'h55, 64'h66);
        set_fwd(0, 1'b1, 1'b1, 5'd9, 64'd0);
        @(negedge clk);
        check("unlisted_rs1_stall", {63'd0, bus.ready_o}, 64'd0);
        @(posedge clk);
        #1;
        set_fwd(0, 1'b1, 1'b0, 5'd9, 64'h59);
        accept("unlisted_rs1_fwd", 64'h59, 64'h66, 64'h59, 64'h66, 2'd0, 2'd0, 0);

        // LUI ignores pending matches on rs1/rs2
        set_instr(OPC_LUI, 5'd9, 5'd9, 64'h55, 64'h66);
        set_fwd(0, 1'b1, 1'b1, 5'd9, 64'h12);
        accept("lui_no_stall", 64'h444, 64'h66, 64'h55, 64'h66, 2'd1, 2'd0, 0);
        clear_fwd();

        // Backpressure: hold first result, stall second, then stream
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
        set_instr(OPC_OP, 5'd1, 5'd2, 64'hA0, 64'hB0);
        accept("bp_first", 64'hA0, 64'hB0, 64'hA0, 64'hB0, 2'd0, 2'd0, 0);
        set_instr(OPC_OP_W, 5'd3, 5'd4, 64'hA1, 64'hB1);
        repeat (4) begin
            @(negedge clk);
            check("bp_ready_low",   {63'd0, bus.ready_o}, 64'd0);
            check("bp_valid_held",  {63'd0, bus.valid_o}, 64'd1);
            check("bp_alu_a_held",  bus.alu_a_o, 64'hA0);
            check("bp_alu_b_held",  bus.alu_b_o, 64'hB0);
        end
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        accept("bp_second", 64'hA1, 64'hB1, 64'hA1, 64'hB1, 2'd0, 2'd0, 0);
        set_instr(OPC_OP, 5'd5, 5'd6, 64'hA2, 64'hB2);
        accept("bp_third", 64'hA2, 64'hB2, 64'hA2, 64'hB2, 2'd0, 2'd0, 0);
        set_instr(OPC_OP, 5'd7, 5'd8, 64'hA3, 64'hB3);
        accept("bp_fourth", 64'hA3, 64'hB3, 64'hA3, 64'hB3, 2'd0, 2'd0, 0);
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Flush kills the held instruction and refuses the incoming one
        bus.ready_i = 1'b0;
        set_instr(OPC_OP, 5'd1, 5'd2, 64'hC0, 64'hC1);
        accept("flush_victim", 64'hC0, 64'hC1, 64'hC0, 64'hC1, 2'd0, 2'd0, 0);
        set_instr(OPC_OP, 5'd3, 5'd4, 64'hE0, 64'hE1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_ready_low", {63'd0, bus.ready_o}, 64'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        if (sb.size() > 0) dropped = sb.pop_back();
        @(negedge clk);
        check("flush_valid_low", {63'd0, bus.valid_o}, 64'd0);
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        set_instr(OPC_OP_IMM, 5'd5, 5'd0, 64'hD0, 64'hD1);
        accept("post_flush", 64'hD0, 64'h111, 64'hD0, 64'hD1, 2'd0, 2'd3, 0);

        // Opcode select sweep, back-to-back
        for (int i = 0; i < 12; i++) begin
            set_instr(sw_op[i], 5'd1, 5'd2, 64'hA1, 64'hB2);
            accept($sformatf("sel_%07b", sw_op[i]), sw_a[i], sw_b[i], 64'hA1, 64'hB2,
                   sw_as[i], sw_bs[i], 0);
        end
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-stall discards the held instruction immediately
        bus.ready_i = 1'b0;
        set_instr(OPC_OP, 5'd1, 5'd2, 64'hF0, 64'hF1);
        accept("rst_victim", 64'hF0, 64'hF1, 64'hF0, 64'hF1, 2'd0, 2'd0, 0);
        bus.valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, bus.valid_o}, 64'd0);
        check("async_rst_alu_a", bus.alu_a_o, 64'd0);
        if (sb.size() > 0) dropped = sb.pop_back();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
